serial_frame_receiver: RTL
==========================

Name: serial_frame_receiver

Overview:
- Downstream consumer of the 13-bit rotating frame serializer.
- Samples the serial stream (serializer q output) on a shared clock, hunts for frame alignment using the fixed sync bits, confirms lock, then extracts the 5-bit payload each frame.
- Reports lock, frame-valid strobe and a sticky sync-loss error.
- Frame in transmit order f0..f12 = 1,1,0,d1,d2,d3,d4,d5,0,1,0,1,1, repeating with no gap.

Parameters:
- CONFIRM, 1, number of additional consecutive matching frames required after the first match before entering LOCKED (1..3).
- MISS_MAX, 2, consecutive mismatching frames in LOCKED that force a return to HUNT (1..3).

Ports:
- io_in[0]  input  1  clk; all state updates on rising edge.
- io_in[1]  input  1  rst_n; synchronous, active-low.
- io_in[2]  input  1  sdata; serial frame bit.
- io_in[3]  input  1  en; sample strobe, sdata shifted in only when 1.
- io_in[7:4]  input  4  unused, ignored.
- io_out[4:0]  output  5  payload; bit0 = d1 (first payload bit received), bit4 = d5.
- io_out[5]  output  1  locked; 1 while in LOCKED.
- io_out[6]  output  1  frame_valid; one-cycle pulse when payload updated.
- io_out[7]  output  1  err; sticky sync-loss flag.

Behaviour:
- Reset (rst_n=0 at a rising edge): window=0, state=HUNT, phase=0, confirm count=0, miss count=0; all io_out bits 0. Reset is honoured mid-frame in any state and overrides en.
- en=0: no register changes except frame_valid, which returns to 0.
- Sample (en=1): window <= {window[11:0], sdata}; window[12] is the oldest bit.
- Match condition on the post-shift window: window[12:10]=110 and window[4:0]=01011. window[9:5] = d1..d5 is don't-care. An all-zero window after reset cannot match because window[12] must be 1.
- HUNT: on a matching sample, go to CONFIRM with phase=0 and confirm count=0. No payload update.
- CONFIRM:
  - phase counts samples 1..13. At the 13th sample phase wraps to 0 and the window is checked.
  - Match: confirm count +1. When it reaches CONFIRM, go to LOCKED, load payload from window[9:5] (d1 to payload[0]) and pulse frame_valid.
  - Mismatch: go to HUNT.
- LOCKED: check the window every 13th sample.
  - Match: load payload, pulse frame_valid, clear miss count.
  - Mismatch: payload holds, no pulse, miss count +1. When miss count reaches MISS_MAX: go to HUNT, locked=0, err=1, miss count=0.
- frame_valid and payload are registered and appear in the cycle following the clock edge that sampled the frame's last bit (f12).
- err clears only on reset. Re-lock after an error is permitted; err stays 1.
- Simultaneous events: a check edge that also completes lock both updates payload and asserts locked on the same edge.
- Alignment: the first alignment satisfying the confirmation wins. Payloads whose rotation aliases the sync bits may lock at a wrong phase; this is documented behaviour and is not corrected.
- Counters are sized for values up to 13; there is no overflow path.

Test Plan:
- Reset then aligned stream, payload d1..d5=1,0,1,1,0, en=1 continuous, defaults → locked=1 and frame_valid pulse after sample 26; io_out[4:0]=5'b01101; pulse repeats every 13 cycles.
- Locked, then one frame with f11 flipped → no pulse for that frame, locked stays 1, err=0; next good frame pulses with the unchanged payload.
- Locked, then two consecutive frames with f2 flipped → after the second check locked=0, err=1, payload holds 5'b01101; a clean stream re-locks within 26 samples with err still 1.
- Stream started 5 bits into a frame (misaligned) → lock achieved on the correct boundary; payload correct at first pulse; no pulse before lock.
- en held low for 7 cycles mid-frame with sdata toggling → outputs and counters frozen; lock kept and next frame decoded correctly after en returns.
- rst_n low for one cycle while locked → io_out=8'h00 on the following cycle; relock requires 26 samples again.

Source files
------------

// File: rtl/serial_frame_receiver_if.sv
// rtl/serial_frame_receiver_if.sv - serial sample stream in, decoded status byte out
interface serial_frame_receiver_if;
    logic       sdata;
    logic       en;
    logic [7:0] io_out;

    modport master (output sdata, output en, input io_out);
    modport slave  (input sdata, input en, output io_out);
endinterface

// File: rtl/serial_frame_receiver.sv
// rtl/serial_frame_receiver.sv - frame aligner and 5-bit payload extractor for 13-bit sync frames
module serial_frame_receiver #(
    parameter int CONFIRM  = 1,
    parameter int MISS_MAX = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    serial_frame_receiver_if.slave        bus
);

    typedef enum logic [1:0] {
        S_HUNT    = 2'd0,
        S_CONFIRM = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    state_t      state_q,       state_d;
    logic [12:0] window_q,      window_d;
    logic [3:0]  phase_q,       phase_d;
    logic [3:0]  confirm_cnt_q, confirm_cnt_d;
    logic [3:0]  miss_cnt_q,    miss_cnt_d;
    logic [4:0]  payload_q,     payload_d;
    logic        frame_valid_q, frame_valid_d;
    logic        err_q,         err_d;

    logic        match;
    logic        frame_end;
    logic [4:0]  window_payload;

    // Register update; reset clears everything regardless of en
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_HUNT;
            window_q      <= '0;
            phase_q       <= '0;
            confirm_cnt_q <= '0;
            miss_cnt_q    <= '0;
            payload_q     <= '0;
            frame_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            window_q      <= window_d;
            phase_q       <= phase_d;
            confirm_cnt_q <= confirm_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            payload_q     <= payload_d;
            frame_valid_q <= frame_valid_d;
            err_q         <= err_d;
        end
    end

    // Shift in a sample, test the sync pattern and advance the alignment FSM
    always_comb begin
        state_d        = state_q;
        window_d       = window_q;
        phase_d        = phase_q;
        confirm_cnt_d  = confirm_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        payload_d      = payload_q;
        frame_valid_d  = 1'b0;
        err_d          = err_q;
        match          = 1'b0;
        frame_end      = 1'b0;
        window_payload = '0;

        if (bus.en) begin
            window_d = {window_q[11:0], bus.sdata};
            // Sync bits: f0..f2 = 110 sit in the oldest slots, f8..f12 = 01011 in the newest
            match = (window_d[12:10] == 3'b110) && (window_d[4:0] == 5'b01011);
            // d1 arrived first so it sits highest in the window; reverse into payload[0]
            window_payload = {window_d[5], window_d[6], window_d[7], window_d[8], window_d[9]};
            frame_end = (phase_q == 4'd12);

            unique case (state_q)
                S_HUNT: begin
                    if (match) begin
                        state_d       = S_CONFIRM;
                        phase_d       = '0;
                        confirm_cnt_d = '0;
                    end
                end
                S_CONFIRM: begin
                    if (frame_end) begin
                        phase_d = '0;
                        if (match) begin
                            if (confirm_cnt_q + 4'd1 == 4'(CONFIRM)) begin
                                state_d       = S_LOCKED;
                                confirm_cnt_d = '0;
                                miss_cnt_d    = '0;
                                payload_d     = window_payload;
                                frame_valid_d = 1'b1;
                            end else begin
                                confirm_cnt_d = confirm_cnt_q + 4'd1;
                            end
                        end else begin
                            state_d = S_HUNT;
                        end
                    end else begin
                        phase_d = phase_q + 4'd1;
                    end
                end
                S_LOCKED: begin
                    if (frame_end) begin
                        phase_d = '0;
                        if (match) begin
                            payload_d     = window_payload;
                            frame_valid_d = 1'b1;
                            miss_cnt_d    = '0;
                        end else if (miss_cnt_q + 4'd1 == 4'(MISS_MAX)) begin
                            state_d    = S_HUNT;
                            err_d      = 1'b1;
                            miss_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 4'd1;
                        end
                    end else begin
                        phase_d = phase_q + 4'd1;
                    end
                end
                default: begin
                    state_d = S_HUNT;
                end
            endcase
        end
    end

    // Status byte: {err, frame_valid, locked, payload}
    always_comb begin
        bus.io_out = {err_q, frame_valid_q, (state_q == S_LOCKED), payload_q};
    end

endmodule
